// File: rtl/freq_div_pkg.sv
// Shared definitions for the programmable clock divider: FSM state
// encoding, reset divisor and smallest divisor that can be applied.
package freq_div_pkg;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } fd_state_e;

    localparam int DEFAULT_DIV = 9;
    localparam int MIN_DIV     = 2;

endpackage

// File: rtl/freq_div_neg_retime.sv
// Falling-edge retime flop. It delays the rising-edge duty signal by half
// an input period so that odd divisors can stretch the high phase.
module freq_div_neg_retime (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic q
);

    // Sample d on the falling edge; reset seen here clears the output
    always_ff @(negedge clk_in) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// Programmable integer clock divider with 50% duty for odd and even
// divisors. Divisor changes are queued and take effect only on a period
// boundary (or immediately while stopped), so the output never shows a
// runt pulse. Stopping is also deferred to the period boundary.
module freq_div_prog #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = freq_div_pkg::DEFAULT_DIV
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         clk_out,
    output logic [W-1:0] div_active,
    output logic         load_pending,
    output logic         div_err
);

    import freq_div_pkg::*;

    localparam logic [W-1:0] DEF_DIV_W = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_DIV_W = W'(MIN_DIV);
    localparam logic [W-1:0] ONE_W     = W'(1);
    localparam logic [W-1:0] ZERO_W    = W'(0);

    fd_state_e    state_r,        state_next_s;
    logic [W-1:0] cnt_r,          cnt_next_s;
    logic         clk_pos_r,      clk_pos_next_s;
    logic [W-1:0] div_active_r,   div_active_next_s;
    logic [W-1:0] pending_r,      pending_next_s;
    logic         load_pending_r, load_pending_next_s;
    logic         div_err_r,      div_err_next_s;

    logic         clk_neg_s;
    logic         boundary_s;
    logic         load_ok_s;
    logic         load_bad_s;
    logic         apply_s;
    logic [W-1:0] cnt_inc_s;
    logic [W-1:0] half_div_s;

    // The boundary edge is the one on which the counter wraps to zero
    assign boundary_s = (state_r == RUNNING) && (cnt_r == (div_active_r - ONE_W));
    assign load_ok_s  = div_load && (div_val >= MIN_DIV_W);
    assign load_bad_s = div_load && (div_val <  MIN_DIV_W);
    // A queued divisor may only replace the active one between periods
    assign apply_s    = load_pending_r && ((state_r == STOPPED) || boundary_s);
    assign cnt_inc_s  = cnt_r + ONE_W;
    assign half_div_s = div_active_r >> 1;

    // Next-state logic for the run/stop FSM, period counter and duty flop
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        clk_pos_next_s = clk_pos_r;
        case (state_r)
            STOPPED: begin
                if (en) begin
                    state_next_s   = RUNNING;
                    cnt_next_s     = ZERO_W;
                    clk_pos_next_s = 1'b1;
                end else begin
                    state_next_s   = STOPPED;
                    cnt_next_s     = ZERO_W;
                    clk_pos_next_s = 1'b0;
                end
            end
            RUNNING: begin
                if (boundary_s) begin
                    if (en) begin
                        // Every divisor is >= 2, so a new period always opens high
                        state_next_s   = RUNNING;
                        cnt_next_s     = ZERO_W;
                        clk_pos_next_s = 1'b1;
                    end else begin
                        state_next_s   = STOPPED;
                        cnt_next_s     = ZERO_W;
                        clk_pos_next_s = 1'b0;
                    end
                end else begin
                    state_next_s   = RUNNING;
                    cnt_next_s     = cnt_inc_s;
                    clk_pos_next_s = (cnt_inc_s < half_div_s);
                end
            end
            default: begin
                state_next_s   = STOPPED;
                cnt_next_s     = ZERO_W;
                clk_pos_next_s = 1'b0;
            end
        endcase
    end

    // Next-state logic for the active/pending divisors and load error pulse
    always_comb begin
        div_active_next_s   = div_active_r;
        pending_next_s      = pending_r;
        load_pending_next_s = load_pending_r;
        div_err_next_s      = load_bad_s;
        if (apply_s) begin
            div_active_next_s = pending_r;
        end else begin
            div_active_next_s = div_active_r;
        end
        // A load on the applying edge re-queues, so the set wins over the clear
        if (load_ok_s) begin
            pending_next_s      = div_val;
            load_pending_next_s = 1'b1;
        end else if (apply_s) begin
            pending_next_s      = pending_r;
            load_pending_next_s = 1'b0;
        end else begin
            pending_next_s      = pending_r;
            load_pending_next_s = load_pending_r;
        end
    end

    // Rising-edge state registers with synchronous reset taking priority
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r        <= STOPPED;
            cnt_r          <= ZERO_W;
            clk_pos_r      <= 1'b0;
            div_active_r   <= DEF_DIV_W;
            pending_r      <= DEF_DIV_W;
            load_pending_r <= 1'b0;
            div_err_r      <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            cnt_r          <= cnt_next_s;
            clk_pos_r      <= clk_pos_next_s;
            div_active_r   <= div_active_next_s;
            pending_r      <= pending_next_s;
            load_pending_r <= load_pending_next_s;
            div_err_r      <= div_err_next_s;
        end
    end

    freq_div_neg_retime u_neg_retime (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (clk_pos_r),
        .q      (clk_neg_s)
    );

    // clk_out is an OR of two flops. clk_neg is low at every boundary, so the
    // parity select may change there without glitching the output.
    assign clk_out      = clk_pos_r | (div_active_r[0] & clk_neg_s);
    assign div_active   = div_active_r;
    assign load_pending = load_pending_r;
    assign div_err      = div_err_r;

endmodule

// File: doc/freq_div_prog.md
FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the divisor width in bits.
REQ-002 The block SHALL have parameter DEFAULT_DIV, default 9, meaning the divisor loaded at reset (legal range 2..2^W-1).
REQ-003 The block SHALL have port clk_in, input, 1 bit: input clock; all state except the odd-mode retime flop is updated on the posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: run request, sampled only at a period boundary or while stopped.
REQ-006 The block SHALL have port div_val, input, W bits: requested divisor N.
REQ-007 The block SHALL have port div_load, input, 1 bit: single-cycle strobe requesting that div_val be loaded.
REQ-008 The block SHALL have port clk_out, output, 1 bit: divided clock.
REQ-009 The block SHALL have port div_active, output, W bits: divisor currently in effect.
REQ-010 The block SHALL have port load_pending, output, 1 bit: a legal divisor is queued and not yet applied.
REQ-011 The block SHALL have port div_err, output, 1 bit: one-cycle pulse flagging a rejected load.

Function
REQ-012 The FSM SHALL have states STOPPED and RUNNING; STOPPED holds cnt=0 and clk_out=0.
REQ-013 The STOPPED to RUNNING transition SHALL occur at the first posedge with en=1; cnt=0 and clk_pos=1 at that edge.
REQ-014 In RUNNING, cnt SHALL increment each posedge and wrap from div_active-1 to 0; the wrap edge is the period boundary.
REQ-015 clk_pos SHALL be registered high for cnt in [0, floor(N/2)-1] and low otherwise.
REQ-016 For even N, clk_out SHALL equal clk_pos: N/2 cycles high, N/2 low.
REQ-017 For odd N, clk_neg SHALL be clk_pos retimed on the clk_in negedge, and clk_out = clk_pos OR clk_neg, giving exactly N/2 input periods high (50% duty).
REQ-018 The divisor SHALL be fixed per period.
REQ-019 A div_load with div_val >= 2 SHALL capture div_val into the pending register and set load_pending the next cycle.
REQ-020 A later legal load before application SHALL overwrite the pending value (last wins).
REQ-021 A pending value SHALL be applied at the next period boundary, or immediately while STOPPED; div_active updates and load_pending clears on that edge.
REQ-022 A div_load with div_val < 2 SHALL be rejected: div_err pulses for exactly one cycle and the pending and active divisors are unchanged.
REQ-023 en=0 sampled at a period boundary SHALL move the FSM to STOPPED; en=0 mid-period SHALL have no effect until the boundary, so no runt pulses occur.
REQ-024 A load and a boundary on the same edge SHALL apply the previously pending value; the new value becomes pending.
REQ-025 Changing the divisor between odd and even values SHALL produce no glitch; clk_neg is 0 at every boundary.

Reset
REQ-026 Reset SHALL set the FSM to STOPPED, cnt=0, clk_pos=0, div_active=DEFAULT_DIV, load_pending=0, div_err=0.
REQ-027 The negedge flop SHALL clear clk_neg when it samples reset high.
REQ-028 clk_out SHALL be 0 no later than the first full clk_in cycle after reset is asserted, including mid-period.
REQ-029 Reset SHALL take priority over div_load and en.

Structure
REQ-030 Package freq_div_pkg SHALL hold the state enum (STOPPED, RUNNING), DEFAULT_DIV, and the minimum-divisor constant 2.
REQ-031 The negedge retime flop with synchronous reset SHALL be the single sub-module, freq_div_neg_retime.
REQ-032 All other logic SHALL reside in freq_div_prog and be 120-400 lines of RTL in total.

Verification
REQ-033 Scenario: reset, then en=1 with DEFAULT_DIV=9 -> clk_out period is 9 input cycles and high time is 4.5 cycles, over 10 periods.
REQ-034 Scenario: load 4 mid-period while N=9 -> the current period completes at 9 cycles, the next is 4 cycles high 2/low 2, and load_pending is high until the boundary.
REQ-035 Scenario: load 1, then load 0 -> div_err pulses once each, and div_active stays 9.
REQ-036 Scenario: load 6, then load 7 in the same period -> the next period uses 7, and 6 is never applied.
REQ-037 Scenario: en dropped at cnt=2 with N=5 -> the period completes, then clk_out stays 0; re-asserting en restarts with clk_out high on the first edge.
REQ-038 Scenario: reset asserted at cnt=3 with N=7 while clk_out is high -> clk_out is 0 within 1 cycle and div_active=9.
